// File: rtl/fwd_scoreboard.sv
// Operand-forwarding select and load-use stall detection for the EX stage, backed by a
// private shift-register scoreboard of the destinations in flight after EX.
module fwd_scoreboard #(
   parameter int unsigned REG_AW   = 3,
   parameter int unsigned STAGES   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned FWD_W   = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic              ex_wr,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic [REG_AW-1:0] ex_a,
   input  logic [REG_AW-1:0] ex_b,
   input  logic [REG_AW-1:0] ex_s,
   input  logic              ex_a_used,
   input  logic              ex_b_used,
   input  logic              ex_s_used,
   output logic [FWD_W-1:0]  fwd_a,
   output logic [FWD_W-1:0]  fwd_b,
   output logic [FWD_W-1:0]  fwd_s,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cycles
);

   logic [STAGES:1]   sb_valid_q;
   logic [STAGES:1]   sb_wr_q;
   logic [STAGES:1]   sb_load_q;
   logic [REG_AW-1:0] sb_dst_q [1:STAGES];
   logic [CNT_W-1:0]  stall_cnt_q;

   logic [STAGES:1]   prod;
   logic [REG_AW-1:0] src [3];
   logic [2:0]        used;
   logic [FWD_W-1:0]  sel [3];
   logic [2:0]        load_hit;

   always_comb begin
      prod = '0;
      for (int k = 1; k <= int'(STAGES); k++) begin
         prod[k] = sb_valid_q[k] && sb_wr_q[k] && !(ZERO_REG && (sb_dst_q[k] == '0));
      end
   end

   always_comb begin
      src[0]   = ex_a;
      src[1]   = ex_b;
      src[2]   = ex_s;
      used     = {ex_s_used, ex_b_used, ex_a_used};
      load_hit = '0;
      for (int i = 0; i < 3; i++) begin
         sel[i] = '0;
         // Walk oldest to youngest so the youngest matching producer is the one left selected.
         for (int k = int'(STAGES); k >= 1; k--) begin
            if (ex_valid && used[i] && prod[k] && (sb_dst_q[k] == src[i])) begin
               sel[i] = FWD_W'(k);
            end
         end
         load_hit[i] = ex_valid && used[i] && prod[1] && sb_load_q[1] && (sb_dst_q[1] == src[i]);
      end
   end

   assign fwd_a        = sel[0];
   assign fwd_b        = sel[1];
   assign fwd_s        = sel[2];
   assign stall        = |load_hit;
   assign stall_cycles = stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_valid_q <= '0;
         sb_wr_q    <= '0;
         sb_load_q  <= '0;
         for (int k = 1; k <= int'(STAGES); k++) begin
            sb_dst_q[k] <= '0;
         end
      end else begin
         for (int k = 2; k <= int'(STAGES); k++) begin
            sb_valid_q[k] <= sb_valid_q[k-1] && !flush;
            sb_wr_q[k]    <= sb_wr_q[k-1];
            sb_load_q[k]  <= sb_load_q[k-1];
            sb_dst_q[k]   <= sb_dst_q[k-1];
         end
         // A stalled cycle pushes a bubble; a redirect squashes everything including EX.
         sb_valid_q[1] <= ex_valid && !stall && !flush;
         sb_wr_q[1]    <= ex_wr;
         sb_load_q[1]  <= ex_is_load;
         sb_dst_q[1]   <= ex_dst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: two instances (default and STAGES=4/REG_AW=5/CNT_W=2) share one
// directed stimulus stream; an issue-history model is compared every cycle plus literal checks.
module tb_fwd_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       ex_valid = 1'b0, ex_wr = 1'b0, ex_is_load = 1'b0;
   logic [4:0] ex_dst = '0, ex_a = '0, ex_b = '0, ex_s = '0;
   logic       ex_a_used = 1'b0, ex_b_used = 1'b0, ex_s_used = 1'b0;

   logic [1:0]  fwd_a0, fwd_b0, fwd_s0;
   logic        stall0;
   logic [15:0] cyc0;
   logic [2:0]  fwd_a1, fwd_b1, fwd_s1;
   logic        stall1;
   logic [1:0]  cyc1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fwd_scoreboard u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_wr(ex_wr),
      .ex_is_load(ex_is_load), .ex_dst(ex_dst[2:0]), .ex_a(ex_a[2:0]), .ex_b(ex_b[2:0]),
      .ex_s(ex_s[2:0]), .ex_a_used(ex_a_used), .ex_b_used(ex_b_used), .ex_s_used(ex_s_used),
      .fwd_a(fwd_a0), .fwd_b(fwd_b0), .fwd_s(fwd_s0), .stall(stall0), .stall_cycles(cyc0)
   );

   fwd_scoreboard #(.REG_AW(5), .STAGES(4), .ZERO_REG(1'b1), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_wr(ex_wr),
      .ex_is_load(ex_is_load), .ex_dst(ex_dst), .ex_a(ex_a), .ex_b(ex_b), .ex_s(ex_s),
      .ex_a_used(ex_a_used), .ex_b_used(ex_b_used), .ex_s_used(ex_s_used),
      .fwd_a(fwd_a1), .fwd_b(fwd_b1), .fwd_s(fwd_s1), .stall(stall1), .stall_cycles(cyc1)
   );

   // Model: hist[i][k] is the instruction issued k cycles ago into instance i (1 = youngest).
   typedef struct {
      bit          v;
      bit          wr;
      bit          ld;
      int unsigned dst;
   } ent_t;

   ent_t        hist [2][1:7];
   int unsigned cnt_m [2];
   bit          st_m;

   function automatic int unsigned mask(input int i);
      return (i == 0) ? 32'd7 : 32'd31;
   endfunction

   function automatic int stg(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   function automatic int unsigned cmax(input int i);
      return (i == 0) ? 32'd65535 : 32'd3;
   endfunction

   function automatic bit producer(input int i, input int k);
      return hist[i][k].v && hist[i][k].wr && (hist[i][k].dst != 0);
   endfunction

   function automatic int unsigned exp_fwd(input int i, input logic [4:0] src, input bit use_it);
      if (!ex_valid || !use_it) return 0;
      for (int k = 1; k <= stg(i); k++) begin
         if (producer(i, k) && (hist[i][k].dst == (32'(src) & mask(i)))) return k;
      end
      return 0;
   endfunction

   function automatic bit exp_stall(input int i);
      return (exp_fwd(i, ex_a, ex_a_used) == 1 || exp_fwd(i, ex_b, ex_b_used) == 1 ||
              exp_fwd(i, ex_s, ex_s_used) == 1) && hist[i][1].ld;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            cnt_m[i] = 0;
            for (int k = 1; k <= 7; k++) hist[i][k] = '{default: 0};
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            st_m = exp_stall(i);
            if (!flush && st_m && cnt_m[i] < cmax(i)) cnt_m[i]++;
            for (int k = 7; k >= 2; k--) hist[i][k] = hist[i][k-1];
            hist[i][1] = '{v: ex_valid && !st_m, wr: ex_wr, ld: ex_is_load,
                           dst: 32'(ex_dst) & mask(i)};
            if (flush) for (int k = 1; k <= 7; k++) hist[i][k].v = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m0.fwd_a", 32'(fwd_a0), exp_fwd(0, ex_a, ex_a_used));
      chk("m0.fwd_b", 32'(fwd_b0), exp_fwd(0, ex_b, ex_b_used));
      chk("m0.fwd_s", 32'(fwd_s0), exp_fwd(0, ex_s, ex_s_used));
      chk("m0.stall", 32'(stall0), 32'(exp_stall(0)));
      chk("m0.cnt", 32'(cyc0), cnt_m[0]);
      chk("m1.fwd_a", 32'(fwd_a1), exp_fwd(1, ex_a, ex_a_used));
      chk("m1.fwd_b", 32'(fwd_b1), exp_fwd(1, ex_b, ex_b_used));
      chk("m1.fwd_s", 32'(fwd_s1), exp_fwd(1, ex_s, ex_s_used));
      chk("m1.stall", 32'(stall1), 32'(exp_stall(1)));
      chk("m1.cnt", 32'(cyc1), cnt_m[1]);
   end

   // Present a new EX instruction one time unit after the rising edge.
   task automatic issue(input bit v, input bit wr, input bit ld, input logic [4:0] dst,
                        input logic [4:0] a, input bit au, input logic [4:0] b, input bit bu,
                        input logic [4:0] s, input bit su, input bit fl);
      @(posedge clk);
      #1;
      ex_valid = v; ex_wr = wr; ex_is_load = ld; ex_dst = dst;
      ex_a = a; ex_a_used = au; ex_b = b; ex_b_used = bu; ex_s = s; ex_s_used = su;
      flush = fl;
      #1;
   endtask

   task automatic hold;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #3;
      chk("rst.fwd_a0", 32'(fwd_a0), 0);
      chk("rst.stall0", 32'(stall0), 0);
      chk("rst.cnt1", 32'(cyc1), 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1, 1, 0, 5'd1, 5'd2, 1, 5'd3, 1, 5'd0, 0, 0);  // add r1
      chk("first.fwd_a0", 32'(fwd_a0), 0);
      issue(1, 1, 0, 5'd2, 5'd1, 1, 5'd3, 1, 5'd0, 0, 0);  // add r2 = r1 + r3
      chk("raw1.fwd_a0", 32'(fwd_a0), 1);
      chk("raw1.fwd_b0", 32'(fwd_b0), 0);
      chk("raw1.stall0", 32'(stall0), 0);
      issue(1, 1, 0, 5'd7, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0);  // reads r1 again
      chk("raw2.fwd_a0", 32'(fwd_a0), 2);
      chk("raw2.fwd_a1", 32'(fwd_a1), 2);

      issue(1, 1, 1, 5'd4, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);  // lw r4
      issue(1, 1, 0, 5'd3, 5'd5, 1, 5'd4, 1, 5'd0, 0, 0);  // add r3 = r5 + r4
      chk("lu.stall0", 32'(stall0), 1);
      chk("lu.fwd_b0", 32'(fwd_b0), 1);
      chk("lu.cnt0", 32'(cyc0), 0);
      hold();
      chk("lu2.stall0", 32'(stall0), 0);
      chk("lu2.fwd_b0", 32'(fwd_b0), 2);
      chk("lu2.cnt0", 32'(cyc0), 1);
      chk("lu2.cnt1", 32'(cyc1), 1);

      issue(1, 1, 0, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);  // r5 older
      issue(1, 1, 0, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);  // r5 younger
      issue(1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0);  // store reads r5 on A and S
      chk("young.fwd_a0", 32'(fwd_a0), 1);
      chk("young.fwd_s0", 32'(fwd_s0), 1);
      chk("young.fwd_s1", 32'(fwd_s1), 1);

      issue(1, 1, 0, 5'd6, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);  // r6
      issue(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);  // writes r0
      issue(1, 1, 0, 5'd3, 5'd0, 1, 5'd6, 0, 5'd0, 0, 0);  // reads r0, immediate on B
      chk("zero.fwd_a0", 32'(fwd_a0), 0);
      chk("imm.fwd_b0", 32'(fwd_b0), 0);
      chk("imm.fwd_b1", 32'(fwd_b1), 0);

      issue(1, 1, 1, 5'd6, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);  // lw r6
      issue(1, 1, 0, 5'd3, 5'd6, 1, 5'd0, 0, 5'd0, 0, 1);  // consumer with redirect
      chk("fl.stall0", 32'(stall0), 1);
      issue(1, 1, 0, 5'd3, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("fl2.stall0", 32'(stall0), 0);
      chk("fl2.fwd_a0", 32'(fwd_a0), 0);
      chk("fl2.cnt0", 32'(cyc0), 1);

      for (int n = 0; n < 5; n++) begin
         issue(1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
         issue(1, 0, 0, 5'd0, 5'd0, 0, 5'd4, 1, 5'd0, 0, 0);
         hold();
      end
      chk("sat.cnt1", 32'(cyc1), 3);
      chk("sat.cnt0", 32'(cyc0), 6);

      issue(1, 1, 0, 5'd17, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);  // producer r17
      for (int n = 1; n <= 5; n++) begin
         issue(1, 0, 0, 5'd0, 5'd17, 1, 5'd0, 0, 5'd0, 0, 0);
         chk("sweep.fwd_a1", 32'(fwd_a1), (n <= 4) ? n : 0);
         chk("sweep.fwd_a0", 32'(fwd_a0), (n <= 2) ? n : 0);
      end

      issue(1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
      issue(1, 0, 0, 5'd0, 5'd0, 0, 5'd4, 1, 5'd0, 0, 0);
      chk("mid.stall1", 32'(stall1), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst.stall1", 32'(stall1), 0);
      chk("arst.stall0", 32'(stall0), 0);
      chk("arst.fwd_b1", 32'(fwd_b1), 0);
      chk("arst.cnt0", 32'(cyc0), 0);
      chk("arst.cnt1", 32'(cyc1), 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
